// File: rtl/mips32_pkg.sv
// Shared types and constants for the MIPS32 fetch stage and its prefetch buffer.
package mips32_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            filled;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/mips32_fetch_buffer.sv
// Slot-reserving prefetch FIFO: slots are allocated at request time and filled
// in order as responses return, so the head is only valid once its word arrives.
module mips32_fetch_buffer
  import mips32_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int PW    = AW + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alloc_en,
  input  logic [XLEN-1:0] alloc_pc,
  input  logic            fill_en,
  input  logic [XLEN-1:0] fill_data,
  input  logic            pop_en,
  input  logic            flush,
  output fetch_entry_t    head_entry,
  output logic [PW-1:0]   count,
  output logic [PW-1:0]   unfilled,
  output logic            fill_pending
);

  fetch_entry_t  entries_q [DEPTH];
  fetch_entry_t  entries_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] fill_q, fill_d;
  logic [PW-1:0] tail_q, tail_d;

  // Pop clears before alloc writes so a full-buffer pop+alloc on the same slot keeps the new entry.
  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    fill_d    = fill_q;
    tail_d    = tail_q;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) entries_d[i] = '0;
      head_d = '0;
      fill_d = '0;
      tail_d = '0;
    end else begin
      if (pop_en) begin
        entries_d[head_q[AW-1:0]] = '0;
        head_d = head_q + PW'(1);
      end
      if (alloc_en) begin
        entries_d[tail_q[AW-1:0]] = '{pc: alloc_pc, instr: '0, filled: 1'b0};
        tail_d = tail_q + PW'(1);
      end
      if (fill_en) begin
        entries_d[fill_q[AW-1:0]].instr  = fill_data;
        entries_d[fill_q[AW-1:0]].filled = 1'b1;
        fill_d = fill_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      head_q <= '0;
      fill_q <= '0;
      tail_q <= '0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      fill_q    <= fill_d;
      tail_q    <= tail_d;
    end
  end

  assign head_entry   = entries_q[head_q[AW-1:0]];
  assign count        = tail_q - head_q;
  assign unfilled     = tail_q - fill_q;
  assign fill_pending = (fill_q != tail_q);

endmodule

// File: rtl/mips32_fetch_stage.sv
// MIPS32 instruction-fetch stage: PC, request credit, redirect drop counting.
// Optional MIPS32_FETCH_PERF_EN adds perf_fetched/perf_stall counters.
module mips32_fetch_stage
  import mips32_pkg::*;
#(
  parameter  int              DEPTH    = 4,
  parameter  logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  localparam int              PW       = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus4,
  input  logic            id_ready
`ifdef MIPS32_FETCH_PERF_EN
  ,
  output logic [XLEN-1:0] perf_fetched,
  output logic [XLEN-1:0] perf_stall
`endif
);

  fetch_entry_t    head_entry;
  logic [PW-1:0]   count, unfilled;
  logic            fill_pending;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [PW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [PW-1:0]   pending_drop;
  logic [PW:0]     occupancy;
  logic            pop, credit, req_fire, rsp_fill;

  assign if_valid    = head_entry.filled;
  assign if_instr    = head_entry.instr;
  assign if_pc       = head_entry.pc;
  assign if_pc_plus4 = head_entry.pc + PC_STEP;
  assign pop         = if_valid && id_ready;

  // Counting the slot freed by this cycle's consume keeps 1 instr/cycle at latency DEPTH-1.
  assign occupancy      = {1'b0, count} + {1'b0, drop_cnt_q} - {{PW{1'b0}}, pop};
  assign credit         = occupancy < (PW+1)'(DEPTH);
  assign imem_req_valid = reset && credit && !redirect_valid;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_fill       = imem_rsp_valid && (drop_cnt_q == '0) && fill_pending && !redirect_valid;

  // A response in the redirect cycle is old-stream and retires one pending drop.
  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    drop_cnt_d   = drop_cnt_q;
    pending_drop = drop_cnt_q + unfilled;
    if (redirect_valid) begin
      fetch_pc_d = word_align(redirect_pc);
      drop_cnt_d = (imem_rsp_valid && (pending_drop != '0)) ? pending_drop - PW'(1) : pending_drop;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + PC_STEP;
      if (imem_rsp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= word_align(RESET_PC);
      drop_cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  mips32_fetch_buffer #(.DEPTH(DEPTH)) u_buffer (
    .clk         (clk),
    .reset       (reset),
    .alloc_en    (req_fire),
    .alloc_pc    (fetch_pc_q),
    .fill_en     (rsp_fill),
    .fill_data   (imem_rsp_data),
    .pop_en      (pop),
    .flush       (redirect_valid),
    .head_entry  (head_entry),
    .count       (count),
    .unfilled    (unfilled),
    .fill_pending(fill_pending)
  );

`ifdef MIPS32_FETCH_PERF_EN
  logic [XLEN-1:0] perf_fetched_q, perf_fetched_d;
  logic [XLEN-1:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q + XLEN'(pop);
    perf_stall_d   = perf_stall_q + XLEN'(id_ready && !if_valid);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: doc/mips32_fetch_stage.md
# mips32_fetch_stage

Instruction-fetch stage feeding the decode stage of `mips32_pipeline`. Owns the program counter, issues in-order word requests to instruction memory over a valid/ready handshake, and buffers returned instructions in a slot-reserving prefetch FIFO. On a branch/jump redirect it discards all buffered and in-flight instructions, then restarts at the new target.

## Interface
- `DEPTH`, 4: prefetch slots; power of two, ≥2; also bounds in-flight requests.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-low (asserted when 0).
- `imem_req_valid` out 1: fetch request present.
- `imem_req_addr` out 32: word address of the request; bits [1:0] always 0.
- `imem_req_ready` in 1: memory accepts the request this cycle.
- `imem_rsp_valid` in 1: instruction word returned; in request order; no backpressure.
- `imem_rsp_data` in 32: returned instruction.
- `redirect_valid` in 1: branch/jump taken; flush and refetch.
- `redirect_pc` in 32: new fetch target; bits [1:0] ignored (treated as 0).
- `if_valid` out 1: `if_instr`/`if_pc` hold a valid instruction.
- `if_instr` out 32: instruction word to decode.
- `if_pc` out 32: address of `if_instr`.
- `if_pc_plus4` out 32: `if_pc + 4`, mod 2^32.
- `id_ready` in 1: decode consumes the head instruction when `if_valid && id_ready`.

## Operation
- State: `fetch_pc`; FIFO of `DEPTH` entries {pc, instr, filled}; pointers `head`, `fill`, `tail`; `drop_cnt` (0..DEPTH).
- Credit: request allowed when `entries + drop_cnt < DEPTH`.
- `imem_req_valid = credit && !redirect_valid`. It may drop without a handshake. Memory acts only on `valid && ready`.
- Accepted request: allocate the slot at `tail` with pc=`fetch_pc`, filled=0. Then `fetch_pc += 4`, wrapping at 2^32, and `tail++`.
- Response with `drop_cnt > 0`: discard it and decrement `drop_cnt`. Otherwise write `imem_rsp_data` into the slot at `fill`, set filled=1, and do `fill++`.
- Output: `if_valid = entry[head].filled`; `if_instr`/`if_pc` come from the head slot. A handshake frees the slot (`head++`).
- Redirect:
  - `drop_cnt += unfilled allocated slots`.
  - Clear all slots; set pointers equal.
  - `fetch_pc <= {redirect_pc[31:2], 2'b00}`.
- Simultaneous events in a redirect cycle:
  - A head consume completes first, and the consumed instruction is valid.
  - A response arriving in the same cycle belongs to the old stream and counts toward the drop total.
  - No request is accepted in a redirect cycle.
- A response arriving with no pending slot and `drop_cnt == 0` is a protocol violation. It is ignored and flagged by a bench assertion.

## Timing
- Reset values: `fetch_pc`=`RESET_PC`, FIFO empty, `drop_cnt`=0, `imem_req_valid`=0, `if_valid`=0, `if_instr`=0, `if_pc`=0, `if_pc_plus4`=4.
- First request is in the first cycle after reset deasserts, with addr=`RESET_PC`.
- Response in cycle N makes `if_valid` high in cycle N+1 (registered fill).
- Sustained throughput is 1 instr/cycle when memory latency < `DEPTH` cycles.
- A redirect in cycle R produces a request to the target in R+1. Old-stream responses never reach `if_valid`.
- Reset asserted mid-operation clears all state immediately. The memory is reset by the same signal and returns no stale responses.

## Configuration
- `MIPS32_FETCH_PERF_EN` defined: adds outputs `perf_fetched` (out 32) and `perf_stall` (out 32). Both reset to 0 and wrap at 2^32.
  - `perf_fetched` counts `if_valid && id_ready` handshakes.
  - `perf_stall` counts cycles with `id_ready && !if_valid`.
- Undefined: the ports and counters do not exist. All other behaviour is identical.

## Structure
- `mips32_pkg` holds:
  - `XLEN`=32.
  - `PC_STEP`=4.
  - `fetch_entry_t` {pc, instr, filled}.
- Sub-module `mips32_fetch_buffer` implements the slot-reserving FIFO: alloc/fill/pop/flush ports, the three pointers, and the entry count. The PC, credit logic and drop counter stay in the top.

## Test plan
- Reset release with a 1-cycle memory where mem[i]=i and `id_ready`=1 → `if_pc` = 0,4,8,… on consecutive cycles, with `if_instr` matching.
- Hold `id_ready`=0 for 10 cycles → exactly `DEPTH` requests issued, then `imem_req_valid`=0. On release, instructions drain in order with no loss.
- 3-cycle memory latency, redirect to 32'h0000_0103 with 2 requests in flight → both stale responses dropped, next `if_pc`=32'h0000_0100, next request the cycle after the redirect.
- Redirect in the same cycle as a head consume and a response → the consumed instruction is delivered once, and the response is dropped.
- Redirect to 32'hFFFF_FFFC → fetches FFFF_FFFC then 0000_0000, and `if_pc_plus4` shows 0 for the first.
- Assert reset low mid-stream → all outputs are at reset values in the same cycle, and fetch restarts at `RESET_PC` after release.
- With `MIPS32_FETCH_PERF_EN`: 5 consumed instructions and 3 starved cycles → `perf_fetched`=5, `perf_stall`=3.
